// File: rtl/if_prefetch_queue_if.sv
// Fetch-side bundle: instruction memory request/ack bus plus the decode-facing
// head-of-queue and stall/redirect controls.
interface if_prefetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst_id;
  logic [31:0] pc_plus_four_id;
  logic        valid_id;

  modport master (
    output imem_req, imem_addr, inst_id, pc_plus_four_id, valid_id,
    input  imem_ack, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_id, pc_plus_four_id, valid_id,
    output imem_ack, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Fetch front end: owns fetch PC, issues one-at-a-time imem requests under a
// FIFO credit check, and presents buffered {inst, pc+4} pairs to decode.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0015
) (
  input  logic               clk,
  input  logic               rst_n,
  if_prefetch_queue_if.master bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } entry_t;

  state_t        state, state_nx;
  entry_t        fifo [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_nx;
  logic [31:0]   fetch_pc, drop_addr, pc4;
  logic          valid, push, pop, credit;

  assign pc4   = fetch_pc + 32'd4;
  assign valid = (count != '0);
  // Redirect wins over everything: no push of the in-flight word, no pop.
  assign push  = (state == REQ) && bus.imem_ack && !bus.redirect;
  assign pop   = valid && !bus.stall && !bus.redirect;

  always_comb begin
    count_nx = count + (AW+1)'(push) - (AW+1)'(pop);
    if (bus.redirect) count_nx = '0;
  end

  // Room for one more word after this edge's push/pop settles.
  assign credit = (count_nx < DEPTH_C);

  // State register
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (credit) state_nx = REQ;
      REQ: begin
        if (bus.imem_ack)        state_nx = credit ? REQ : IDLE;
        else if (bus.redirect)   state_nx = DROP;
      end
      DROP: if (bus.imem_ack) state_nx = REQ;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: DROP keeps presenting the abandoned address until its ack.
  always_comb begin
    bus.imem_req  = (state != IDLE);
    bus.imem_addr = (state == DROP) ? drop_addr : fetch_pc;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fetch_pc  <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      count <= count_nx;
      if (bus.redirect) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fetch_pc <= bus.redirect_pc & ~32'h3;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + 1'b1;
          fetch_pc <= pc4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
      if ((state == REQ) && !bus.imem_ack && bus.redirect) drop_addr <= fetch_pc;
    end
  end

  always_ff @(negedge clk) begin
    if (push) fifo[wr_ptr] <= '{inst: bus.imem_rdata, pc4: pc4};
  end

  assign bus.valid_id        = valid;
  assign bus.inst_id         = valid ? fifo[rd_ptr].inst : NOP_INST;
  assign bus.pc_plus_four_id = valid ? fifo[rd_ptr].pc4  : 32'h0;
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: per-cycle vector table for the
// streaming/stall/wrap run, plus hand sequences for DROP, redirect+ack, reset.
module tb_if_prefetch_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   mem_lat = 0;
  int   mem_cnt;
  int   n_chk = 0;
  int   n_pass = 0;

  if_prefetch_queue_if bus();

  if_prefetch_queue #(
    .DEPTH(4), .RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0015)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory model: ack on the (mem_lat+1)-th cycle of a held request.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n)                              mem_cnt <= 0;
    else if (bus.imem_req && !bus.imem_ack)  mem_cnt <= mem_cnt + 1;
    else                                     mem_cnt <= 0;
  end
  assign bus.imem_ack   = bus.imem_req && (mem_cnt == mem_lat);
  assign bus.imem_rdata = bus.imem_addr | 32'h0000_1000;

  typedef struct {
    logic        stall;
    logic        rd;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] inst;
    logic [31:0] pc4;
  } vec_t;

  vec_t tbl [27];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic look(input string nm, input logic req, input logic [31:0] addr,
                      input logic vld, input logic [31:0] inst, input logic [31:0] pc4);
    chk({nm, ".req"}, 32'(bus.imem_req), 32'(req));
    if (req) chk({nm, ".addr"}, bus.imem_addr, addr);
    chk({nm, ".valid"}, 32'(bus.valid_id), 32'(vld));
    chk({nm, ".inst"}, bus.inst_id, inst);
    chk({nm, ".pc4"}, bus.pc_plus_four_id, pc4);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves time at posedge+1 of cycle 0, before the first active (falling) edge.
  task automatic do_reset(input int lat);
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    mem_lat = lat;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    //           stall rd rpc           req addr          vld inst          pc4
    tbl[0]  = '{1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h15,     32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,      1'b1, 32'h0,      1'b0, 32'h15,     32'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,      1'b1, 32'h4,      1'b1, 32'h1000,   32'h4};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,      1'b1, 32'h8,      1'b1, 32'h1004,   32'h8};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,      1'b1, 32'hC,      1'b1, 32'h1008,   32'hC};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,      1'b1, 32'h10,     1'b1, 32'h100C,   32'h10};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,      1'b1, 32'h14,     1'b1, 32'h1010,   32'h14};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,      1'b1, 32'h18,     1'b1, 32'h1014,   32'h18};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,      1'b1, 32'h1C,     1'b1, 32'h1014,   32'h18};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,      1'b1, 32'h20,     1'b1, 32'h1014,   32'h18};
    for (int i = 10; i <= 16; i++)
      tbl[i] = '{1'b1, 1'b0, 32'h0,     1'b0, 32'h0,      1'b1, 32'h1014,   32'h18};
    tbl[17] = '{1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 32'h1014,   32'h18};
    tbl[18] = '{1'b0, 1'b0, 32'h0,      1'b1, 32'h24,     1'b1, 32'h1018,   32'h1C};
    tbl[19] = '{1'b0, 1'b0, 32'h0,      1'b1, 32'h28,     1'b1, 32'h101C,   32'h20};
    tbl[20] = '{1'b0, 1'b0, 32'h0,      1'b1, 32'h2C,     1'b1, 32'h1020,   32'h24};
    tbl[21] = '{1'b0, 1'b0, 32'h0,      1'b1, 32'h30,     1'b1, 32'h1024,   32'h28};
    tbl[22] = '{1'b0, 1'b0, 32'h0,      1'b1, 32'h34,     1'b1, 32'h1028,   32'h2C};
    tbl[23] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h38,  1'b1, 32'h102C,   32'h30};
    tbl[24] = '{1'b0, 1'b0, 32'h0,      1'b1, 32'hFFFF_FFFC, 1'b0, 32'h15,  32'h0};
    tbl[25] = '{1'b0, 1'b0, 32'h0,      1'b1, 32'h0,      1'b1, 32'hFFFF_FFFC, 32'h0};
    tbl[26] = '{1'b0, 1'b0, 32'h0,      1'b1, 32'h4,      1'b1, 32'h1000,   32'h4};

    // Zero-wait streaming, stall fill/drain, then wrap redirect.
    do_reset(0);
    for (int i = 0; i < 27; i++) begin
      bus.stall       = tbl[i].stall;
      bus.redirect    = tbl[i].rd;
      bus.redirect_pc = tbl[i].rpc;
      look($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].inst, tbl[i].pc4);
      step();
    end

    // Latency 3: redirect to misaligned 0x102 while the 0x8 request is pending.
    do_reset(2);
    repeat (7) step();
    look("drop_pre", 1'b1, 32'h8, 1'b1, 32'h1004, 32'h8);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0102;
    step();
    bus.redirect = 1'b0;
    look("drop_hold", 1'b1, 32'h8, 1'b0, 32'h15, 32'h0);
    step();
    look("drop_ack", 1'b1, 32'h8, 1'b0, 32'h15, 32'h0);
    step();
    look("drop_new", 1'b1, 32'h100, 1'b0, 32'h15, 32'h0);
    step();
    look("drop_wait1", 1'b1, 32'h100, 1'b0, 32'h15, 32'h0);
    step();
    look("drop_wait2", 1'b1, 32'h100, 1'b0, 32'h15, 32'h0);
    step();
    look("drop_first", 1'b1, 32'h104, 1'b1, 32'h1100, 32'h104);

    // Redirect coinciding with ack, under stall.
    do_reset(2);
    bus.stall = 1'b1;
    repeat (3) step();
    look("rdack_pre", 1'b1, 32'h0, 1'b0, 32'h15, 32'h0);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0200;
    step();
    bus.redirect = 1'b0;
    look("rdack_flush", 1'b1, 32'h200, 1'b0, 32'h15, 32'h0);
    repeat (3) step();
    look("rdack_first", 1'b1, 32'h204, 1'b1, 32'h1200, 32'h204);

    // Async reset mid-burst with three entries buffered and a request pending.
    do_reset(2);
    bus.stall = 1'b1;
    repeat (10) step();
    look("arst_pre", 1'b1, 32'hC, 1'b1, 32'h1000, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    look("arst_now", 1'b0, 32'h0, 1'b0, 32'h15, 32'h0);
    do_reset(0);
    look("arst_c0", 1'b0, 32'h0, 1'b0, 32'h15, 32'h0);
    step();
    look("arst_c1", 1'b1, 32'h0, 1'b0, 32'h15, 32'h0);
    step();
    look("arst_c2", 1'b1, 32'h4, 1'b1, 32'h1000, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
